// File: rtl/hash_result_scanner.sv
// Read-only scanner over the per-nonce hash records. It reads H0 of every nonce and reports
// the first nonce with H0 below the target, plus the minimum H0 and the nonce that produced it.
module hash_result_scanner #(
    parameter  int unsigned NUM_NONCES = 16,
    localparam int unsigned NW         = $clog2(NUM_NONCES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [15:0]   hash_addr,
    input  logic [31:0]   target,
    output logic          done,
    output logic          found,
    output logic [NW-1:0] first_nonce,
    output logic [31:0]   min_h0,
    output logic [NW-1:0] min_nonce,
    output logic          mem_clk,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    localparam logic [NW-1:0] LAST_NONCE = NW'(NUM_NONCES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          accept;
    logic          issuing;
    logic [NW-1:0] issue_cnt;
    logic [31:0]   target_q;
    logic          vld0;
    logic          vld1;
    logic [NW-1:0] tag0;
    logic [NW-1:0] tag1;

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_write_data = 32'd0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issuing   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issuing = 1'b1;
                if (issue_cnt == LAST_NONCE) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The final read is being captured on this edge
                if (vld1 && !vld0) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address issue, nonce-tag pipeline and result accumulation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            found       <= 1'b0;
            first_nonce <= '0;
            min_h0      <= 32'd0;
            min_nonce   <= '0;
            mem_addr    <= 16'd0;
            target_q    <= 32'd0;
            issue_cnt   <= '0;
            vld0        <= 1'b0;
            vld1        <= 1'b0;
            tag0        <= '0;
            tag1        <= '0;
        end else begin
            done <= (state == REPORT);
            vld0 <= accept | issuing;
            vld1 <= vld0;
            tag1 <= tag0;

            if (vld1) begin
                // Strict less-than keeps the lower nonce on ties
                if (tag1 == '0 || mem_read_data < min_h0) begin
                    min_h0    <= mem_read_data;
                    min_nonce <= tag1;
                end
                if (mem_read_data < target_q && !found) begin
                    found       <= 1'b1;
                    first_nonce <= tag1;
                end
            end

            if (accept) begin
                mem_addr    <= hash_addr;
                target_q    <= target;
                issue_cnt   <= NW'(1);
                tag0        <= '0;
                found       <= 1'b0;
                first_nonce <= '0;
                min_h0      <= 32'd0;
                min_nonce   <= '0;
            end else if (issuing) begin
                mem_addr  <= mem_addr + 16'd8;
                tag0      <= issue_cnt;
                issue_cnt <= issue_cnt + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hash_result_scanner.sv
// Bench for hash_result_scanner: a synchronous-read memory model feeds the scanner, and the
// expected results come from a direct search over the H0 values the bench placed in memory.
module tb_hash_result_scanner;

    localparam int N  = 16;
    localparam int NW = 4;
    localparam int RW = 1 + NW + 32 + NW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   hash_addr = 16'd0;
    logic [31:0]   target = 32'd0;
    logic          done;
    logic          found;
    logic [NW-1:0] first_nonce;
    logic [31:0]   min_h0;
    logic [NW-1:0] min_nonce;
    logic          mem_clk;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data = 32'd0;

    logic [31:0] mem [65536];
    logic [31:0] h0 [N];

    int n_pass = 0;
    int n_total = 0;

    // Results of the most recent scan
    logic [RW-1:0] obs_res;
    int            done_cycle;
    int            done_count;
    int            addr_errs;

    hash_result_scanner #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hash_addr(hash_addr), .target(target),
        .done(done), .found(found), .first_nonce(first_nonce), .min_h0(min_h0),
        .min_nonce(min_nonce), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: address seen on an edge returns data after it
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    function automatic logic [RW-1:0] model(input logic [31:0] tgt);
        logic          ef = 1'b0;
        int            efirst = 0;
        logic [31:0]   emin = h0[0];
        int            eminn = 0;
        for (int i = 0; i < N; i++) begin
            if (!ef && h0[i] < tgt) begin
                ef = 1'b1;
                efirst = i;
            end
            if (h0[i] < emin) begin
                emin = h0[i];
                eminn = i;
            end
        end
        return {ef, NW'(efirst), emin, NW'(eminn)};
    endfunction

    task automatic load(input logic [15:0] ha);
        for (int i = 0; i < N; i++) mem[16'(ha + 16'(8 * i))] = h0[i];
    endtask

    // Start one scan and observe addresses, done timing and results; busy_at>0 pulses start mid-scan
    task automatic run_scan(input logic [15:0] ha, input logic [31:0] tgt, input int busy_at);
        load(ha);
        done_cycle = -1;
        done_count = 0;
        addr_errs  = 0;
        obs_res    = '0;
        @(negedge clk);
        hash_addr = ha;
        target    = tgt;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (mem_addr !== ha) addr_errs++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k < N && mem_addr !== 16'(ha + 16'(8 * k))) addr_errs++;
            if (done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle = k;
                    obs_res = {found, first_nonce, min_h0, min_nonce};
                end
            end
            if (busy_at > 0 && k == busy_at) start = 1'b1;
            if (busy_at > 0 && k == busy_at + 1) start = 1'b0;
        end
    endtask

    task automatic check_scan(input string name, input logic [RW-1:0] exp_res);
        n_total++;
        if (obs_res !== exp_res) $display("FAIL %s results: got %h want %h", name, obs_res, exp_res);
        else n_pass++;
        n_total++;
        if (done_cycle != 18 || done_count != 1)
            $display("FAIL %s done: got cycle %0d count %0d want cycle 18 count 1", name, done_cycle, done_count);
        else n_pass++;
        n_total++;
        if (addr_errs != 0) $display("FAIL %s addresses: got %0d wrong want 0", name, addr_errs);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({done, found, first_nonce, min_h0, min_nonce, mem_addr, mem_we, mem_write_data} !== '0)
            $display("FAIL reset outputs: got %h %h %h %h %h %h want all 0",
                     done, found, first_nonce, min_h0, min_nonce, mem_addr);
        else n_pass++;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) h0[i] = 32'(100 + i);
        run_scan(16'h0010, 32'd103, 0);
        check_scan("ramp", {1'b1, 4'd0, 32'd100, 4'd0});
    endtask

    task automatic test_single_hit();
        for (int i = 0; i < N; i++) h0[i] = 32'hFFFF_FFFF;
        h0[9] = 32'd5;
        run_scan(16'h0200, 32'd6, 0);
        check_scan("single_hit", {1'b1, 4'd9, 32'd5, 4'd9});
    endtask

    task automatic test_ties();
        for (int i = 0; i < N; i++) h0[i] = 32'h0000_1000 + 32'(i);
        h0[3] = 32'h10;
        h0[7] = 32'h10;
        run_scan(16'h0300, 32'h10, 0);
        check_scan("ties", {1'b0, 4'd0, 32'h10, 4'd3});
    endtask

    task automatic test_wrap();
        for (int i = 0; i < N; i++) h0[i] = $urandom_range(1000, 5000);
        h0[2] = 32'd7;
        run_scan(16'hFFF8, 32'd900, 0);
        check_scan("wrap", model(32'd900));
    endtask

    task automatic test_target_zero();
        for (int i = 0; i < N; i++) h0[i] = $urandom_range(0, 3);
        run_scan(16'h0500, 32'd0, 0);
        check_scan("target_zero", model(32'd0));
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [31:0] tgt;
            logic [15:0] ha;
            for (int i = 0; i < N; i++) h0[i] = (it % 2 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            tgt = (it % 2 == 0) ? 32'($urandom_range(0, 1200)) : $urandom;
            ha  = 16'($urandom);
            run_scan(ha, tgt, 0);
            check_scan($sformatf("random%0d", it), model(tgt));
        end
    endtask

    task automatic test_reset_mid_scan();
        int stray_done = 0;
        for (int i = 0; i < N; i++) h0[i] = 32'(50 - i);
        load(16'h0600);
        @(negedge clk);
        hash_addr = 16'h0600;
        target    = 32'd45;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({done, found, first_nonce, min_h0, min_nonce, mem_addr} !== '0)
            $display("FAIL midscan_reset outputs: got %h %h %h %h %h %h want all 0",
                     done, found, first_nonce, min_h0, min_nonce, mem_addr);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1 if (done) stray_done++;
        end
        n_total++;
        if (stray_done != 0) $display("FAIL midscan_reset no_done: got %0d pulses want 0", stray_done);
        else n_pass++;
        run_scan(16'h0600, 32'd45, 0);
        check_scan("after_reset", {1'b1, 4'd6, 32'd35, 4'd15});
    endtask

    task automatic test_busy_start();
        for (int i = 0; i < N; i++) h0[i] = $urandom_range(0, 500);
        run_scan(16'h0700, 32'd250, 3);
        check_scan("busy_start", model(32'd250));
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] exp_a;
        logic [RW-1:0] exp_b;
        logic [RW-1:0] got_a = '0;
        logic [RW-1:0] got_b = '0;
        int pulses = 0;
        int at_a = -1;
        int at_b = -1;
        for (int i = 0; i < N; i++) h0[i] = $urandom_range(0, 300);
        load(16'h0100);
        exp_a = model(32'd100);
        for (int i = 0; i < N; i++) h0[i] = $urandom_range(200, 900);
        load(16'h0400);
        exp_b = model(32'd400);
        @(negedge clk);
        hash_addr = 16'h0100;
        target    = 32'd100;
        start     = 1'b1;
        @(posedge clk);
        #1;
        hash_addr = 16'h0400;
        target    = 32'd400;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (at_a < 0) begin
                    at_a = k;
                    got_a = {found, first_nonce, min_h0, min_nonce};
                end else if (at_b < 0) begin
                    at_b = k;
                    got_b = {found, first_nonce, min_h0, min_nonce};
                end
            end
            if (k == 20) start = 1'b0;
        end
        n_total++;
        if (pulses != 2 || at_a != 18 || at_b != 37)
            $display("FAIL b2b done: got %0d pulses at %0d,%0d want 2 at 18,37", pulses, at_a, at_b);
        else n_pass++;
        n_total++;
        if (got_a !== exp_a) $display("FAIL b2b first: got %h want %h", got_a, exp_a);
        else n_pass++;
        n_total++;
        if (got_b !== exp_b) $display("FAIL b2b second: got %h want %h", got_b, exp_b);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_single_hit();
        test_ties();
        test_wrap();
        test_target_zero();
        test_random();
        test_reset_mid_scan();
        test_busy_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
